// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StCsum,
    StRun,
    StErr
  } state_e;

  localparam int unsigned IMEM_AW_DEF    = 8;
  localparam int unsigned IMEM_DW_DEF    = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_packer.sv
// Assembles MSB-first bytes into an instruction word and counts bytes within the word.
module prog_loader_packer
  import prog_loader_pkg::*;
#(
  parameter int unsigned IMEM_DW = IMEM_DW_DEF
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic [7:0]         byte_i,
  output logic [IMEM_DW-1:0] word_o,
  output logic               last_o
);

  logic [IMEM_DW-1:0] word_q;
  logic [1:0]         cnt_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (shift_en_i) begin
      word_q <= {word_q[IMEM_DW-9:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_o = word_q;
  // High while the byte being shifted in completes the word.
  assign last_o = (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a header/words/checksum byte stream into instruction memory,
// then releases the core from reset if the checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF,
  parameter int unsigned IMEM_DW = IMEM_DW_DEF
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [IMEM_DW-1:0] imem_din,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  localparam int unsigned CW = (IMEM_AW + 1 > 8) ? IMEM_AW + 1 : 8;

  state_e             state_q;
  logic [7:0]         n_q;
  logic [7:0]         xor_q;
  logic [IMEM_AW-1:0] addr_q;
  logic               ready_q;
  logic               we_q;
  logic               cpu_rst_q;
  logic               done_q;
  logic               err_q;

  logic          accept;
  logic          begin_load;
  logic          pk_last;
  logic [CW-1:0] wr_cnt_next;
  logic [CW-1:0] n_ext;

  assign accept      = byte_valid & ready_q;
  assign begin_load  = start & (state_q == StIdle || state_q == StRun || state_q == StErr);
  assign wr_cnt_next = CW'(addr_q) + CW'(1);
  assign n_ext       = CW'(n_q);

  prog_loader_packer #(
    .IMEM_DW(IMEM_DW)
  ) u_packer (
    .clock     (clock),
    .rst       (rst),
    .clr_i     (begin_load),
    .shift_en_i(accept && (state_q == StData)),
    .byte_i    (byte_data),
    .word_o    (imem_din),
    .last_o    (pk_last)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= StIdle;
      n_q       <= '0;
      xor_q     <= '0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StIdle, StRun, StErr: begin
          if (start) begin
            state_q   <= StHdr;
            addr_q    <= '0;
            xor_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b1;
          end
        end
        StHdr: begin
          if (accept) begin
            n_q     <= byte_data;
            xor_q   <= xor_q ^ byte_data;
            state_q <= (byte_data == 8'd0) ? StCsum : StData;
          end
        end
        StData: begin
          if (accept) begin
            xor_q <= xor_q ^ byte_data;
            if (pk_last) begin
              state_q <= StWrite;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end
          end
        end
        StWrite: begin
          addr_q  <= addr_q + 1'b1;
          ready_q <= 1'b1;
          state_q <= (wr_cnt_next == n_ext) ? StCsum : StData;
        end
        StCsum: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (byte_data == xor_q) begin
              state_q   <= StRun;
              cpu_rst_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a stream-level reference model.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_din;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream_q[$];
  logic [7:0]  wr_a[$];
  logic [31:0] wr_d[$];

  always #5 clock = ~clock;

  prog_loader dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  // Every cycle with imem_we high is one recorded write.
  always @(negedge clock) begin
    if (imem_we) begin
      wr_a.push_back(imem_addr);
      wr_d.push_back(imem_din);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    cnt = 0;
    while (!byte_ready && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    checks++;
    if (!byte_ready) begin
      errors++;
      $display("FAIL byte_accept_timeout: byte_ready=%0b required 1", byte_ready);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Header N, N random words, checksum (optionally corrupted).
  task automatic build_stream(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < n * 4; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      x ^= b;
    end
    stream_q.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
  endtask

  task automatic run_session(input int gapmax, input string name);
    int n;
    logic [7:0] x;
    bit ok;
    logic [31:0] w;
    n = int'(stream_q[0]);
    x = 8'h00;
    for (int i = 0; i < stream_q.size() - 1; i++) x ^= stream_q[i];
    ok = (stream_q[stream_q.size() - 1] == x);
    wr_a.delete();
    wr_d.delete();
    pulse_start();
    for (int i = 0; i < stream_q.size(); i++)
      send_byte(stream_q[i], $urandom_range(0, gapmax));
    repeat (3) @(negedge clock);
    checks++;
    if (wr_a.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_a.size(), n);
    end
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      w = {stream_q[1 + 4 * i], stream_q[2 + 4 * i], stream_q[3 + 4 * i], stream_q[4 + 4 * i]};
      checks++;
      if (wr_a[i] !== 8'(i) || wr_d[i] !== w) begin
        errors++;
        $display("FAIL %s write%0d: got addr %h data %h required addr %h data %h",
                 name, i, wr_a[i], wr_d[i], 8'(i), w);
      end
    end
    checks++;
    if (done !== ok || err !== !ok || cpu_rst !== !ok || byte_ready !== 1'b0
        || imem_addr !== 8'(n)) begin
      errors++;
      $display("FAIL %s final: done=%b err=%b cpu_rst=%b rdy=%b addr=%h required %b %b %b 0 %h",
               name, done, err, cpu_rst, byte_ready, imem_addr, ok, !ok, !ok, 8'(n));
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (cpu_rst !== 1'b1 || byte_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 8'h00
        || imem_din !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: cpu_rst=%b rdy=%b we=%b addr=%h din=%h done=%b err=%b required 1 0 0 00 0 0 0",
               name, cpu_rst, byte_ready, imem_we, imem_addr, imem_din, done, err);
    end
  endtask

  task automatic load_directed();
    logic [7:0] d[8];
    logic [7:0] x;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    stream_q.delete();
    stream_q.push_back(8'h02);
    x = 8'h02;
    foreach (d[i]) begin
      stream_q.push_back(d[i]);
      x ^= d[i];
    end
    stream_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_two_words();
    load_directed();
    run_session(0, "two_words");
  endtask

  task automatic test_empty();
    stream_q.delete();
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h00);
    run_session(0, "empty");
  endtask

  task automatic test_bad_csum();
    stream_q.delete();
    stream_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    run_session(0, "bad_csum");
  endtask

  task automatic test_gaps();
    load_directed();
    run_session(3, "gaps");
  endtask

  task automatic test_mid_reset();
    load_directed();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(stream_q[i], 0);
    rst = 1'b1;
    @(negedge clock);
    check_reset_values("mid_reset_asserted");
    @(negedge clock);
    rst = 1'b0;
    wr_a.delete();
    wr_d.delete();
    repeat (10) @(negedge clock);
    checks++;
    if (wr_a.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_no_write: got %0d writes required 0", wr_a.size());
    end
    check_reset_values("mid_reset_idle");
    run_session(1, "mid_reset_restart");
  endtask

  task automatic test_restart_from_run();
    build_stream(1, 1'b0);
    run_session(0, "pre_restart");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_cpu_rst: cpu_rst=%b done=%b rdy=%b required 1 0 1",
               cpu_rst, done, byte_ready);
    end
    // Complete the reload begun by that start pulse; words must land from addr 0.
    build_stream(2, 1'b0);
    wr_a.delete();
    wr_d.delete();
    for (int i = 0; i < stream_q.size(); i++) send_byte(stream_q[i], $urandom_range(0, 2));
    repeat (3) @(negedge clock);
    checks++;
    if (wr_a.size() != 2 || wr_a[0] !== 8'h00 || wr_d[0] !== {stream_q[1], stream_q[2],
        stream_q[3], stream_q[4]} || done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL restart_reload: writes=%0d done=%b cpu_rst=%b required 2 1 0",
               wr_a.size(), done, cpu_rst);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      build_stream($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
      run_session($urandom_range(0, 3), $sformatf("random%0d", t));
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(negedge clock);
    test_reset();
    test_two_words();
    test_empty();
    test_bad_csum();
    test_gaps();
    test_mid_reset();
    test_restart_from_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
